// File: rtl/miss_refill_if.sv
// Refill memory port between the miss arbiter and the L2/bus side.
// The arbiter holds req/addr/is_d stable until ack; done/err close the refill.
interface miss_refill_if #(
  parameter int AW = 32
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_is_d;
  logic          mem_ack;
  logic          mem_done;
  logic          mem_err;

  modport master (
    output mem_req, mem_addr, mem_is_d,
    input  mem_ack, mem_done, mem_err
  );

  modport slave (
    input  mem_req, mem_addr, mem_is_d,
    output mem_ack, mem_done, mem_err
  );
endinterface

// File: rtl/miss_refill_arb.sv
// Per-thread I/D miss capture and round-robin refill sequencing onto one
// memory port; wakes or errors the thread when its refill closes.
module miss_refill_arb #(
  parameter  int NTRD    = 8,
  parameter  int AW      = 32,
  parameter  int TIMEOUT = 255,
  localparam int TW      = $clog2(NTRD),
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_miss,
  input  logic [TW-1:0]   i_miss_trd,
  input  logic [AW-1:0]   i_miss_pc,
  input  logic            d_miss,
  input  logic [TW-1:0]   d_miss_trd,
  input  logic [AW-1:0]   d_miss_addr,
  input  logic            kill,
  input  logic [TW-1:0]   kill_trd,
  miss_refill_if.master   mem,
  output logic [NTRD-1:0] blk_trd,
  output logic            wake_vld,
  output logic [TW-1:0]   wake_trd,
  output logic            err_vld,
  output logic [TW-1:0]   err_trd,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  localparam logic [AW-1:0] AMASK = ~(AW'(3));

  state_e          state_q, state_d;
  logic [NTRD-1:0] pend_q, pend_d;
  logic [AW-1:0]   slot_addr_q [NTRD];
  logic [AW-1:0]   slot_addr_d [NTRD];
  logic [NTRD-1:0] slot_d_q, slot_d_d;
  logic [TW-1:0]   svc_q, svc_d;
  logic [TW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic            disc_q, disc_d;
  logic            req_q, req_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            isd_q, isd_d;
  logic            wake_vld_q, wake_vld_d;
  logic [TW-1:0]   wake_trd_q, wake_trd_d;
  logic            err_vld_q, err_vld_d;
  logic [TW-1:0]   err_trd_q, err_trd_d;

  logic [NTRD-1:0] kill_oh;
  logic [NTRD-1:0] svc_oh;
  logic [NTRD-1:0] avail;
  logic            d_cap;
  logic            i_cap;
  logic            pick_vld;
  logic [TW-1:0]   pick_trd;
  logic [TW-1:0]   scan;
  logic            svc_kill;
  logic            drop;

  // Kill and in-service one-hots, plus miss capture eligibility.
  always_comb begin
    kill_oh = '0;
    svc_oh  = '0;
    if (kill) kill_oh[kill_trd] = 1'b1;
    if (state_q != IDLE) svc_oh[svc_q] = 1'b1;
    d_cap = d_miss & ~pend_q[d_miss_trd]
          & ~svc_oh[d_miss_trd] & ~kill_oh[d_miss_trd];
    i_cap = i_miss & ~(d_miss & (d_miss_trd == i_miss_trd))
          & ~pend_q[i_miss_trd] & ~svc_oh[i_miss_trd]
          & ~kill_oh[i_miss_trd];
    svc_kill = kill & (state_q != IDLE) & (kill_trd == svc_q);
    drop     = disc_q | svc_kill;
  end

  // Round-robin pick: first pending thread after rr_q, wrapping.
  always_comb begin
    avail    = pend_q & ~kill_oh;
    pick_vld = 1'b0;
    pick_trd = rr_q;
    scan     = rr_q;
    for (int k = NTRD; k >= 1; k--) begin
      scan = TW'((int'(rr_q) + k) % NTRD);
      if (avail[scan]) begin
        pick_vld = 1'b1;
        pick_trd = scan;
      end
    end
  end

  // Next-state: slot capture, refill FSM, pulses.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q & ~kill_oh;
    slot_addr_d = slot_addr_q;
    slot_d_d    = slot_d_q;
    svc_d       = svc_q;
    rr_d        = rr_q;
    tmo_d       = tmo_q;
    disc_d      = disc_q | svc_kill;
    req_d       = req_q;
    addr_d      = addr_q;
    isd_d       = isd_q;
    wake_vld_d  = 1'b0;
    wake_trd_d  = wake_trd_q;
    err_vld_d   = 1'b0;
    err_trd_d   = err_trd_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          svc_d            = pick_trd;
          pend_d[pick_trd] = 1'b0;
          addr_d = slot_addr_q[pick_trd] & AMASK;
          isd_d  = slot_d_q[pick_trd];
          disc_d  = 1'b0;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (mem.mem_err || tmo_q == CW'(TIMEOUT)) begin
          err_vld_d = ~drop;
          if (!drop) err_trd_d = svc_q;
          rr_d    = svc_q;
          disc_d  = 1'b0;
          state_d = IDLE;
        end else if (mem.mem_done) begin
          wake_vld_d = ~drop;
          if (!drop) wake_trd_d = svc_q;
          rr_d    = svc_q;
          disc_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (d_cap) begin
      pend_d[d_miss_trd]      = 1'b1;
      slot_addr_d[d_miss_trd] = d_miss_addr;
      slot_d_d[d_miss_trd]    = 1'b1;
    end
    if (i_cap) begin
      pend_d[i_miss_trd]      = 1'b1;
      slot_addr_d[i_miss_trd] = i_miss_pc;
      slot_d_d[i_miss_trd]    = 1'b0;
    end
  end

  // State and registered outputs; async reset drops everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      for (int i = 0; i < NTRD; i++) slot_addr_q[i] <= '0;
      slot_d_q   <= '0;
      svc_q      <= '0;
      rr_q       <= TW'(NTRD - 1);
      tmo_q      <= '0;
      disc_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      isd_q      <= 1'b0;
      wake_vld_q <= 1'b0;
      wake_trd_q <= '0;
      err_vld_q  <= 1'b0;
      err_trd_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      slot_addr_q <= slot_addr_d;
      slot_d_q    <= slot_d_d;
      svc_q       <= svc_d;
      rr_q        <= rr_d;
      tmo_q       <= tmo_d;
      disc_q      <= disc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      isd_q       <= isd_d;
      wake_vld_q  <= wake_vld_d;
      wake_trd_q  <= wake_trd_d;
      err_vld_q   <= err_vld_d;
      err_trd_q   <= err_trd_d;
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_is_d = isd_q;
  assign blk_trd      = pend_q | svc_oh;
  assign wake_vld     = wake_vld_q;
  assign wake_trd     = wake_trd_q;
  assign err_vld      = err_vld_q;
  assign err_trd      = err_trd_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_miss_refill_arb.sv
// Bench for miss_refill_arb: directed scenarios plus random traffic,
// every cycle compared against a thread-level reference model.
module tb_miss_refill_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_miss = 1'b0;
  logic [2:0]  i_miss_trd = '0;
  logic [31:0] i_miss_pc = '0;
  logic        d_miss = 1'b0;
  logic [2:0]  d_miss_trd = '0;
  logic [31:0] d_miss_addr = '0;
  logic        kill = 1'b0;
  logic [2:0]  kill_trd = '0;
  logic [7:0]  blk_trd;
  logic        wake_vld;
  logic [2:0]  wake_trd;
  logic        err_vld;
  logic [2:0]  err_trd;
  logic        busy;

  miss_refill_if #(.AW(32)) mif ();

  miss_refill_arb #(.NTRD(8), .AW(32), .TIMEOUT(255)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_miss      (i_miss),
    .i_miss_trd  (i_miss_trd),
    .i_miss_pc   (i_miss_pc),
    .d_miss      (d_miss),
    .d_miss_trd  (d_miss_trd),
    .d_miss_addr (d_miss_addr),
    .kill        (kill),
    .kill_trd    (kill_trd),
    .mem         (mif),
    .blk_trd     (blk_trd),
    .wake_vld    (wake_vld),
    .wake_trd    (wake_trd),
    .err_vld     (err_vld),
    .err_trd     (err_trd),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: pending set, one in-flight refill record
  bit          m_pend [8];
  logic [31:0] m_saddr [8];
  bit          m_sd [8];
  int          m_rr;
  bit          m_act, m_acked, m_disc;
  int          m_svc, m_age;
  logic [31:0] m_addr;
  bit          m_isd;
  bit          m_wake, m_errp;
  int          m_wtrd, m_etrd;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < 8; t++) begin
      m_pend[t] = 0; m_saddr[t] = '0; m_sd[t] = 0;
    end
    m_rr = 7; m_act = 0; m_acked = 0; m_disc = 0;
    m_svc = 0; m_age = 0; m_addr = '0; m_isd = 0;
    m_wake = 0; m_errp = 0; m_wtrd = 0; m_etrd = 0;
  endtask

  task automatic model_step();
    bit op [8];
    bit oact;
    int osvc, kt, dt, it;
    bit found;
    bit drop;
    op = m_pend; oact = m_act; osvc = m_svc;
    kt = kill ? int'(kill_trd) : -1;
    m_wake = 0; m_errp = 0;
    if (!m_act) begin
      found = 0;
      for (int k = 1; k <= 8; k++) begin
        int t;
        t = (m_rr + k) % 8;
        if (!found && m_pend[t] && t != kt) begin
          found = 1; m_act = 1; m_acked = 0; m_disc = 0;
          m_svc = t; m_pend[t] = 0;
          m_addr = m_saddr[t] & ~32'h3; m_isd = m_sd[t];
        end
      end
    end else if (!m_acked) begin
      if (kt == m_svc) m_disc = 1;
      if (mif.mem_ack) begin m_acked = 1; m_age = 0; end
    end else begin
      drop = m_disc || (kt == m_svc);
      if (mif.mem_err || m_age == 255) begin
        if (!drop) begin m_errp = 1; m_etrd = m_svc; end
        m_act = 0; m_rr = m_svc; m_disc = 0;
      end else if (mif.mem_done) begin
        if (!drop) begin m_wake = 1; m_wtrd = m_svc; end
        m_act = 0; m_rr = m_svc; m_disc = 0;
      end else begin
        m_age++;
        if (kt == m_svc) m_disc = 1;
      end
    end
    if (kt >= 0) m_pend[kt] = 0;
    dt = int'(d_miss_trd); it = int'(i_miss_trd);
    if (d_miss && dt != kt && !op[dt] && !(oact && osvc == dt)) begin
      m_pend[dt] = 1; m_saddr[dt] = d_miss_addr; m_sd[dt] = 1;
    end
    if (i_miss && !(d_miss && dt == it) && it != kt && !op[it]
        && !(oact && osvc == it)) begin
      m_pend[it] = 1; m_saddr[it] = i_miss_pc; m_sd[it] = 0;
    end
  endtask

  task automatic compare_all();
    logic [7:0] mb;
    bit mreq;
    mb = '0;
    for (int t = 0; t < 8; t++) mb[t] = m_pend[t];
    if (m_act) mb[m_svc] = 1'b1;
    mreq = m_act && !m_acked;
    check("mem_req", mif.mem_req, mreq);
    if (mreq) begin
      check("mem_addr", mif.mem_addr, m_addr);
      check("mem_is_d", mif.mem_is_d, m_isd);
    end
    check("blk_trd", blk_trd, mb);
    check("busy", busy, m_act);
    check("wake_vld", wake_vld, m_wake);
    if (m_wake) check("wake_trd", wake_trd, m_wtrd);
    check("err_vld", err_vld, m_errp);
    if (m_errp) check("err_trd", err_trd, m_etrd);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    i_miss = 0; d_miss = 0; kill = 0;
    mif.mem_ack = 0; mif.mem_done = 0; mif.mem_err = 0;
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!mif.mem_req && n < 40) begin tick(); n++; end
    check("req_seen", mif.mem_req, 1'b1);
  endtask

  task automatic serve(input int ack_dly, input int done_dly,
                       output logic wv, output logic [2:0] wt);
    wait_req();
    repeat (ack_dly) tick();
    mif.mem_ack = 1;
    tick();
    repeat (done_dly) tick();
    mif.mem_done = 1;
    tick();
    wv = wake_vld;
    wt = wake_trd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       wv;
    logic [2:0] wt;
    int         exp3 [3];
    int         cnt;
    mif.mem_ack = 0; mif.mem_done = 0; mif.mem_err = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("rst_blk", blk_trd, 8'h00);
    rst_n = 1;

    // basic I-miss refill
    i_miss = 1; i_miss_trd = 3; i_miss_pc = 32'h1006;
    tick();
    check("t1_blk", blk_trd, 8'h08);
    check("t1_noreq", mif.mem_req, 1'b0);
    tick();
    check("t1_req", mif.mem_req, 1'b1);
    check("t1_addr", mif.mem_addr, 32'h1004);
    check("t1_isd", mif.mem_is_d, 1'b0);
    mif.mem_ack = 1;
    tick();
    repeat (3) tick();
    mif.mem_done = 1;
    tick();
    check("t1_wake", wake_vld, 1'b1);
    check("t1_wtrd", wake_trd, 3'd3);
    check("t1_blk0", blk_trd, 8'h00);
    tick();
    check("t1_pulse", wake_vld, 1'b0);

    // same-thread I and D miss: D wins
    i_miss = 1; i_miss_trd = 2; i_miss_pc = 32'h300;
    d_miss = 1; d_miss_trd = 2; d_miss_addr = 32'h200;
    tick();
    tick();
    check("t2_isd", mif.mem_is_d, 1'b1);
    check("t2_addr", mif.mem_addr, 32'h200);
    mif.mem_ack = 1; tick();
    mif.mem_done = 1; tick();
    check("t2_wtrd", wake_trd, 3'd2);
    tick();

    // round-robin order after rr_ptr=5
    d_miss = 1; d_miss_trd = 5; d_miss_addr = 32'h500;
    tick();
    wait_req();
    mif.mem_ack = 1; tick();
    i_miss = 1; i_miss_trd = 1; i_miss_pc = 32'h1100;
    d_miss = 1; d_miss_trd = 6; d_miss_addr = 32'h600;
    tick();
    mif.mem_done = 1; tick();
    check("t3_w5", wake_trd, 3'd5);
    d_miss = 1; d_miss_trd = 5; d_miss_addr = 32'h504;
    tick();
    exp3 = '{6, 1, 5};
    for (int j = 0; j < 3; j++) begin
      serve(1, 2, wv, wt);
      check("t3_wake", wv, 1'b1);
      check("t3_order", wt, exp3[j]);
    end
    tick();

    // timeout
    i_miss = 1; i_miss_trd = 0; i_miss_pc = 32'h4000;
    tick();
    wait_req();
    mif.mem_ack = 1; tick();
    cnt = 0;
    while (!err_vld && cnt < 300) begin tick(); cnt++; end
    check("t4_cycles", cnt, 256);
    check("t4_etrd", err_trd, 3'd0);
    check("t4_nowake", wake_vld, 1'b0);
    tick();
    check("t4_idle", busy, 1'b0);

    // kill in WAIT, then kill of a pending thread
    d_miss = 1; d_miss_trd = 4; d_miss_addr = 32'h4400;
    tick();
    wait_req();
    mif.mem_ack = 1; tick();
    kill = 1; kill_trd = 4; tick();
    mif.mem_done = 1; tick();
    check("t5_nowake", wake_vld, 1'b0);
    check("t5_noerr", err_vld, 1'b0);
    tick();
    i_miss = 1; i_miss_trd = 2; i_miss_pc = 32'h2200;
    tick();
    d_miss = 1; d_miss_trd = 7; d_miss_addr = 32'h7700;
    tick();
    kill = 1; kill_trd = 7; tick();
    check("t5_k7blk", blk_trd[7], 1'b0);
    serve(0, 1, wv, wt);
    check("t5_w2", wt, 3'd2);
    repeat (10) tick();
    check("t5_k7req", mif.mem_req, 1'b0);

    // async reset during WAIT
    i_miss = 1; i_miss_trd = 1; i_miss_pc = 32'h1234;
    tick();
    wait_req();
    mif.mem_ack = 1; tick();
    tick();
    #2 rst_n = 0;
    #1;
    check("t6_req", mif.mem_req, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_blk", blk_trd, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    mif.mem_done = 1;
    tick();
    check("t6_nowake", wake_vld, 1'b0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      i_miss      = ($urandom_range(3) == 0);
      i_miss_trd  = 3'($urandom_range(7));
      i_miss_pc   = $urandom;
      d_miss      = ($urandom_range(3) == 0);
      d_miss_trd  = 3'($urandom_range(7));
      d_miss_addr = $urandom;
      kill        = ($urandom_range(15) == 0);
      kill_trd    = 3'($urandom_range(7));
      mif.mem_ack  = ($urandom_range(1) == 0);
      mif.mem_done = ($urandom_range(7) == 0);
      mif.mem_err  = ($urandom_range(31) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
